// File: rtl/frame_sequencer_if.sv
// rtl/frame_sequencer_if.sv - pixel in/out, detector and status bundle of frame_sequencer
interface frame_sequencer_if #(
  parameter int CNTW = 16
);
  logic            start;
  logic [7:0]      din;
  logic            valid;
  logic            det_valid;
  logic            det_hit;
  logic [7:0]      pix_out;
  logic            pix_valid;
  logic [9:0]      row;
  logic [9:0]      col;
  logic            interior;
  logic            sof;
  logic            eol;
  logic            eof;
  logic            busy;
  logic [CNTW-1:0] feature_count;
  logic            count_valid;
  logic            err;

  modport master (
    output start, din, valid, det_valid, det_hit,
    input  pix_out, pix_valid, row, col, interior, sof, eol, eof,
    input  busy, feature_count, count_valid, err
  );

  modport slave (
    input  start, din, valid, det_valid, det_hit,
    output pix_out, pix_valid, row, col, interior, sof, eol, eof,
    output busy, feature_count, count_valid, err
  );
endinterface

// File: rtl/frame_sequencer.sv
// rtl/frame_sequencer.sv - recovers row/col from a blanked pixel stream, forwards armed well-formed frames, counts hits
module frame_sequencer #(
  parameter int WIDTH  = 800,
  parameter int HEIGHT = 600,
  parameter int BORDER = 3,
  parameter int DRAIN  = 16,
  parameter int CNTW   = 16
) (
  input  logic             clock,
  input  logic             reset,
  frame_sequencer_if.slave bus
);
  typedef enum logic [2:0] {IDLE, SYNC, ACTIVE, BLANK, FLUSH, DONE} state_t;

  localparam int              DW       = $clog2(DRAIN + 1);
  localparam logic [9:0]      COL_LAST = 10'(WIDTH - 1);
  localparam logic [9:0]      ROW_LAST = 10'(HEIGHT - 1);
  localparam logic [9:0]      EDGE_LO  = 10'(BORDER);
  localparam logic [9:0]      ROW_HI   = 10'(HEIGHT - BORDER);
  localparam logic [9:0]      COL_HI   = 10'(WIDTH - BORDER);
  localparam logic [CNTW-1:0] CNT_MAX  = '1;

  state_t        state, state_n;
  logic          seen_low, seen_low_n;
  logic [9:0]    row_q, col_q, row_n, col_n;
  logic [DW-1:0] drain_q, drain_n;
  logic          fwd, line_end, frame_end, in_body;
  logic [9:0]    fwd_row, fwd_col;
  logic          err_set, restart, count_done, counting, hit;

  // row_q/col_q hold the position the next accepted pixel will take
  always_comb begin
    state_n    = state;
    seen_low_n = seen_low;
    row_n      = row_q;
    col_n      = col_q;
    drain_n    = '0;
    fwd        = 1'b0;
    fwd_row    = row_q;
    fwd_col    = col_q;
    err_set    = 1'b0;
    restart    = 1'b0;
    count_done = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_n    = SYNC;
          seen_low_n = 1'b0;
          restart    = 1'b1;
        end
      end
      SYNC: begin
        if (!bus.valid) begin
          seen_low_n = 1'b1;
        end else if (seen_low) begin
          fwd     = 1'b1;
          fwd_row = '0;
          fwd_col = '0;
        end
      end
      ACTIVE: begin
        if (bus.valid) begin
          fwd = 1'b1;
        end else begin
          err_set    = 1'b1;
          state_n    = SYNC;
          seen_low_n = 1'b1;
        end
      end
      BLANK: begin
        // seen_low is reused here to mean "at least one blanking cycle since eol"
        if (!bus.valid) begin
          seen_low_n = 1'b1;
        end else if (seen_low) begin
          fwd = 1'b1;
        end else begin
          err_set    = 1'b1;
          state_n    = SYNC;
          seen_low_n = 1'b0;
        end
      end
      FLUSH: begin
        drain_n = drain_q + DW'(1);
        if (drain_q == DW'(DRAIN - 1)) begin
          state_n    = DONE;
          count_done = 1'b1;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase

    line_end  = fwd && (fwd_col == COL_LAST);
    frame_end = line_end && (fwd_row == ROW_LAST);
    if (fwd) begin
      if (frame_end) begin
        state_n = FLUSH;
      end else if (line_end) begin
        state_n    = BLANK;
        seen_low_n = 1'b0;
        row_n      = fwd_row + 10'd1;
        col_n      = '0;
      end else begin
        state_n = ACTIVE;
        row_n   = fwd_row;
        col_n   = fwd_col + 10'd1;
      end
    end

    in_body  = (fwd_row >= EDGE_LO) && (fwd_row < ROW_HI) &&
               (fwd_col >= EDGE_LO) && (fwd_col < COL_HI);
    counting = (state == SYNC) || (state == ACTIVE) || (state == BLANK) || (state == FLUSH);
    hit      = counting && bus.det_valid && bus.det_hit;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      seen_low <= 1'b0;
      row_q    <= '0;
      col_q    <= '0;
      drain_q  <= '0;
    end else begin
      state    <= state_n;
      seen_low <= seen_low_n;
      row_q    <= row_n;
      col_q    <= col_n;
      drain_q  <= drain_n;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      bus.pix_out       <= '0;
      bus.pix_valid     <= 1'b0;
      bus.row           <= '0;
      bus.col           <= '0;
      bus.interior      <= 1'b0;
      bus.sof           <= 1'b0;
      bus.eol           <= 1'b0;
      bus.eof           <= 1'b0;
      bus.busy          <= 1'b0;
      bus.feature_count <= '0;
      bus.count_valid   <= 1'b0;
      bus.err           <= 1'b0;
    end else begin
      bus.pix_valid   <= fwd;
      bus.interior    <= fwd && in_body;
      bus.sof         <= fwd && (state == SYNC);
      bus.eol         <= line_end;
      bus.eof         <= frame_end;
      bus.busy        <= (state_n != IDLE);
      bus.count_valid <= count_done;
      if (fwd) begin
        bus.pix_out <= bus.din;
        bus.row     <= fwd_row;
        bus.col     <= fwd_col;
      end
      if (restart) begin
        bus.err <= 1'b0;
      end else if (err_set) begin
        bus.err <= 1'b1;
      end
      // a discarded frame keeps its hits; only an accepted start clears the total
      if (restart) begin
        bus.feature_count <= '0;
      end else if (hit && (bus.feature_count != CNT_MAX)) begin
        bus.feature_count <= bus.feature_count + 1'b1;
      end
    end
  end
endmodule

// File: doc/frame_sequencer.md
# frame_sequencer

Frame/line sequencer that sits between the raw pixel stream and the corner-check pipeline. It recovers row/column position from a valid-gated stream with blanking gaps and forwards only pixels belonging to an armed, well-formed frame. It tags each forwarded pixel with interior/edge status and frame/line markers. It also counts detector hits for the frame and reports the total once the pipeline has drained.

## Interface
- `WIDTH`, 800, valid pixels per line
- `HEIGHT`, 600, lines per frame
- `BORDER`, 3, pixels on each edge excluded from `interior`
- `DRAIN`, 16, cycles after last pixel to keep counting detector hits (≥1)
- `CNTW`, 16, width of `feature_count`

- `clock` in 1: single clock, all logic posedge
- `reset` in 1: synchronous, active-high
- `start` in 1: arm capture of next frame (1-cycle pulse; ignored unless IDLE)
- `din` in 8: pixel
- `valid` in 1: `din` valid; low = blanking
- `det_valid` in 1: detector output valid (from check pipeline)
- `det_hit` in 1: detector reports a feature (qualified by `det_valid`)
- `pix_out` out 8: forwarded pixel
- `pix_valid` out 1: `pix_out` valid; drives datapath valid
- `row` out 10: row of forwarded pixel
- `col` out 10: column of forwarded pixel
- `interior` out 1: `BORDER ≤ row < HEIGHT-BORDER` and `BORDER ≤ col < WIDTH-BORDER`
- `sof` out 1: with first pixel of frame
- `eol` out 1: with last pixel of each line
- `eof` out 1: with last pixel of frame
- `busy` out 1: state ≠ IDLE
- `feature_count` out CNTW: hits counted this frame, saturating
- `count_valid` out 1: 1-cycle pulse, `feature_count` final
- `err` out 1: sticky malformed-line flag; cleared by accepted `start`

## Operation
- States: IDLE, SYNC, ACTIVE, BLANK, FLUSH, DONE.
- **IDLE:** nothing forwarded.
  - `start` → SYNC.
  - On that transition, clear `feature_count` and `err`, and clear the internal `seen_low` flag.
- **SYNC:** set `seen_low` on any cycle with `valid`=0.
  - `valid`=1 with `seen_low`=1 → accept pixel as row 0, col 0 (`sof`=1) → ACTIVE.
  - `valid`=1 without `seen_low` → discard; mid-line stream is never captured.
- **ACTIVE:** each `valid`=1 cycle forwards one pixel and increments col.
  - Pixel at col WIDTH-1 asserts `eol`. The state then moves to BLANK, or to FLUSH if row = HEIGHT-1, in which case `eof`=1 too.
  - `valid`=0 before col WIDTH-1 (short line) → set `err`, discard frame → SYNC with `seen_low`=1.
- **BLANK:** first cycle after a line end must have `valid`=0.
  - `valid`=1 on that cycle (overlong line) → set `err`, discard → SYNC with `seen_low`=0.
  - After ≥1 low cycle, `valid`=1 → pixel is col 0 of row+1, forwarded same cycle → ACTIVE.
- **FLUSH:** count DRAIN cycles, ignore `valid`, then → DONE.
- **DONE:** `count_valid`=1 for one cycle → IDLE. `feature_count` holds until next accepted `start`.
- Hit counting: `det_valid && det_hit` increments `feature_count` in SYNC, ACTIVE, BLANK and FLUSH; the count saturates at 2^CNTW−1.
- A discarded frame does not clear the count; the frame that finally completes reports the total accumulated since `start`.
- `start` outside IDLE is ignored. Reset in any state → IDLE; all outputs and counters are 0.

## Timing
- All outputs are registered.
- `pix_out`, `pix_valid`, `row`, `col`, `interior`, `sof`, `eol` and `eof` appear 1 cycle after the accepting `din`/`valid` cycle.
- Markers are asserted only while `pix_valid`=1.
- Hit counting: `feature_count` reflects a hit 1 cycle after `det_valid && det_hit`.
- Completion: `count_valid` rises DRAIN+1 cycles after the cycle that accepted the final pixel.
- Minimum blanking: 1 cycle. Back-to-back valid is required within a line.
- Reset values: all outputs 0, state IDLE.
- Throughput: 1 pixel/cycle, no backpressure.

## Test plan
- **Nominal frame.** WIDTH=8, HEIGHT=4, BORDER=1, DRAIN=4. Sequence: `start`, 3 low cycles, 4×(8 valid + 2 low).
  - Expect 32 `pix_valid` and `sof` on (0,0).
  - `eol` on col 7 of each row; `eof` on (3,7).
  - `interior` only for rows 1–2, cols 1–6 (12 pixels).
  - `count_valid` 5 cycles after the last accepted pixel.
- **Mid-line arm.** `start` asserted while `valid` is high mid-line → zero pixels forwarded until after the next low cycle; that following line is row 0.
- **Hit counting.** 5 hits pulsed during ACTIVE and 2 during FLUSH → `feature_count`=7 at `count_valid`.
  - With CNTW=2, 6 hits → count saturates at 3.
- **Short line.** Row 1 has only 5 valid pixels → `err`=1, state back to SYNC.
  - Next well-formed frame completes with `count_valid`; `err` stays 1 until next `start`.
- **Overlong line.** 9 consecutive valid pixels → `err`=1 on the 9th, no `eol` for a 9th pixel, and `col` never exceeds 7.
- **Reset and start gating.** Reset at row 2: the next cycle has all outputs 0 and `busy`=0. `start` while `busy`=1 leaves the count and state unaffected.
